time_scan_cnt: RTL and testbench

Minutes:seconds timekeeping core for the UART-controlled clock. It counts BCD time MM:SS from a parameterised 1 Hz tick and accepts time-set commands from the UART command path. It time-multiplexes the four digits onto a single 4-bit `data` bus with an active-low digit select. It feeds the 7-segment decoder stage directly downstream.

---
 rtl/time_scan_cnt.sv | 120 ++++++++++++
 tb/tb_time_scan_cnt.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/time_scan_cnt.sv
// MM:SS BCD timekeeping core with a set handshake and a 4-digit time-multiplexed
// scan output (one digit value on data, active-low one-hot dig_sel).
module time_scan_cnt #(
    parameter int TICK_DIV = 50_000_000,
    parameter int SCAN_DIV = 50_000
) (
    input  logic        clk,
    input  logic        resett,
    input  logic        run_en,
    input  logic        set_valid,
    input  logic [15:0] set_data,
    output logic        set_ready,
    output logic        set_err,
    output logic        sec_pulse,
    output logic [15:0] time_bcd,
    output logic [3:0]  data,
    output logic [3:0]  dig_sel
);
    localparam int TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]        scan_idx_q, scan_idx_d;
    logic [15:0]       time_q, time_d, time_inc;
    logic              pulse_q, pulse_d;
    logic              err_q, err_d;
    logic              ready_q;
    logic [3:0]        data_q, data_d;
    logic [3:0]        sel_q, sel_d;

    logic set_take, set_ok, tick_wrap;
    logic c0, c1, c2;

    assign set_take  = set_valid && ready_q;
    assign set_ok    = (set_data[15:12] <= 4'd5) && (set_data[11:8] <= 4'd9) &&
                       (set_data[7:4]   <= 4'd5) && (set_data[3:0]  <= 4'd9);
    assign tick_wrap = run_en && (tick_cnt_q == TICK_LAST);

    // Each digit is its own mod-N counter; carries ripple upward.
    always_comb begin
        c0 = (time_q[3:0]  == 4'd9);
        c1 = c0 && (time_q[7:4]  == 4'd5);
        c2 = c1 && (time_q[11:8] == 4'd9);
        time_inc[3:0]   = c0 ? 4'd0 : time_q[3:0] + 4'd1;
        time_inc[7:4]   = !c0 ? time_q[7:4]
                        : (time_q[7:4] == 4'd5) ? 4'd0 : time_q[7:4] + 4'd1;
        time_inc[11:8]  = !c1 ? time_q[11:8]
                        : (time_q[11:8] == 4'd9) ? 4'd0 : time_q[11:8] + 4'd1;
        time_inc[15:12] = !c2 ? time_q[15:12]
                        : (time_q[15:12] == 4'd5) ? 4'd0 : time_q[15:12] + 4'd1;
    end

    // A valid set overrides a coincident tick wrap; an invalid one leaves it alone.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        time_d     = time_q;
        pulse_d    = 1'b0;
        err_d      = set_take && !set_ok;
        if (set_take && set_ok) begin
            time_d     = set_data;
            tick_cnt_d = '0;
        end else if (tick_wrap) begin
            time_d     = time_inc;
            tick_cnt_d = '0;
            pulse_d    = 1'b1;
        end else if (run_en) begin
            tick_cnt_d = tick_cnt_q + 1'b1;
        end
    end

    always_comb begin
        scan_cnt_d = scan_cnt_q + 1'b1;
        scan_idx_d = scan_idx_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            scan_idx_d = scan_idx_q + 2'd1;
        end
        sel_d = ~(4'b0001 << scan_idx_q);
        case (scan_idx_q)
            2'd0:    data_d = time_q[3:0];
            2'd1:    data_d = time_q[7:4];
            2'd2:    data_d = time_q[11:8];
            default: data_d = time_q[15:12];
        endcase
    end

    always_ff @(posedge clk) begin
        if (resett) begin
            tick_cnt_q <= '0;
            scan_cnt_q <= '0;
            scan_idx_q <= '0;
            time_q     <= '0;
            pulse_q    <= 1'b0;
            err_q      <= 1'b0;
            ready_q    <= 1'b0;
            data_q     <= '0;
            sel_q      <= 4'b1110;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
            time_q     <= time_d;
            pulse_q    <= pulse_d;
            err_q      <= err_d;
            ready_q    <= 1'b1;
            data_q     <= data_d;
            sel_q      <= sel_d;
        end
    end

    assign set_ready = ready_q;
    assign set_err   = err_q;
    assign sec_pulse = pulse_q;
    assign time_bcd  = time_q;
    assign data      = data_q;
    assign dig_sel   = sel_q;
endmodule

// File: tb/tb_time_scan_cnt.sv
// Directed bench for time_scan_cnt with TICK_DIV=4, SCAN_DIV=3; expected values
// are hand-derived edge by edge from reset release.
module tb_time_scan_cnt;
    logic        clk = 1'b0;
    logic        resett, run_en, set_valid;
    logic [15:0] set_data;
    logic        set_ready, set_err, sec_pulse;
    logic [15:0] time_bcd;
    logic [3:0]  data, dig_sel;

    int total = 0;
    int bad   = 0;

    time_scan_cnt #(.TICK_DIV(4), .SCAN_DIV(3)) dut (
        .clk(clk), .resett(resett), .run_en(run_en),
        .set_valid(set_valid), .set_data(set_data),
        .set_ready(set_ready), .set_err(set_err), .sec_pulse(sec_pulse),
        .time_bcd(time_bcd), .data(data), .dig_sel(dig_sel)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] dexp [4];
        int idx;
        dexp[0] = 4'd4; dexp[1] = 4'd3; dexp[2] = 4'd2; dexp[3] = 4'd1;

        // Reset state
        resett = 1'b1; run_en = 1'b1; set_valid = 1'b0; set_data = 16'h0;
        step(); step();
        chk("rst_time",  time_bcd, 16'h0000);
        chk("rst_data",  {12'h0, data}, 16'h0);
        chk("rst_sel",   {12'h0, dig_sel}, 16'hE);
        chk("rst_pulse", {15'h0, sec_pulse}, 16'h0);
        chk("rst_err",   {15'h0, set_err}, 16'h0);
        chk("rst_ready", {15'h0, set_ready}, 16'h0);

        // First tick lands on the 4th edge after release
        resett = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("first_pulse", {15'h0, sec_pulse}, (k == 4) ? 16'h1 : 16'h0);
            if (k == 1) chk("ready_up", {15'h0, set_ready}, 16'h1);
        end
        chk("first_time", time_bcd, 16'h0001);

        // Valid set then two wraps 59:58 -> 59:59 -> 00:00
        set_valid = 1'b1; set_data = 16'h5958;
        step();
        set_valid = 1'b0;
        chk("set_time",  time_bcd, 16'h5958);
        chk("set_noerr", {15'h0, set_err}, 16'h0);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("wrap_pulse", {15'h0, sec_pulse}, (k == 4 || k == 8) ? 16'h1 : 16'h0);
            if (k == 4) chk("t5959", time_bcd, 16'h5959);
        end
        chk("t0000", time_bcd, 16'h0000);

        // Invalid sets: error pulse, time and tick untouched
        set_valid = 1'b1; set_data = 16'h0960;
        step();
        chk("bad1_err",  {15'h0, set_err}, 16'h1);
        chk("bad1_time", time_bcd, 16'h0000);
        set_valid = 1'b0;
        step();
        chk("bad1_clr", {15'h0, set_err}, 16'h0);
        set_valid = 1'b1; set_data = 16'hA000;
        step();
        chk("bad2_err",  {15'h0, set_err}, 16'h1);
        chk("bad2_time", time_bcd, 16'h0000);
        set_valid = 1'b0;
        step();
        chk("bad2_clr",   {15'h0, set_err}, 16'h0);
        chk("bad_tick",   {15'h0, sec_pulse}, 16'h1);
        chk("bad_tick_t", time_bcd, 16'h0001);

        // Set coincident with tick wrap: set wins, no pulse
        step(); step(); step();
        chk("pre_coll", {15'h0, sec_pulse}, 16'h0);
        set_valid = 1'b1; set_data = 16'h1234;
        step();
        set_valid = 1'b0;
        chk("coll_time",  time_bcd, 16'h1234);
        chk("coll_pulse", {15'h0, sec_pulse}, 16'h0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("coll_next", {15'h0, sec_pulse}, (k == 4) ? 16'h1 : 16'h0);
        end
        chk("coll_1235", time_bcd, 16'h1235);

        // Scan: resync via reset, hold time at 12:34 with run_en=0
        resett = 1'b1;
        step();
        resett = 1'b0; run_en = 1'b0;
        step();                                   // edge 1
        set_valid = 1'b1; set_data = 16'h1234;
        step();                                   // edge 2: set lands
        set_valid = 1'b0;
        chk("scan_e2_sel",  {12'h0, dig_sel}, 16'hE);
        chk("scan_e2_data", {12'h0, data}, 16'h0);
        for (int k = 3; k <= 14; k++) begin
            step();
            idx = ((k - 1) / 3) % 4;
            chk("scan_sel",   {12'h0, dig_sel}, {12'h0, ~(4'b0001 << idx)});
            chk("scan_data",  {12'h0, data}, {12'h0, dexp[idx]});
            chk("scan_frz",   time_bcd, 16'h1234);
            chk("scan_pulse", {15'h0, sec_pulse}, 16'h0);
        end

        // Mid-count reset at 00:42 discards an in-flight set
        run_en = 1'b1; set_valid = 1'b1; set_data = 16'h0042;
        step();
        set_valid = 1'b0;
        chk("mid_set", time_bcd, 16'h0042);
        step(); step();
        resett = 1'b1; set_valid = 1'b1; set_data = 16'h0555;
        step();
        chk("mid_time",  time_bcd, 16'h0000);
        chk("mid_sel",   {12'h0, dig_sel}, 16'hE);
        chk("mid_ready", {15'h0, set_ready}, 16'h0);
        resett = 1'b0; set_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("mid_pulse", {15'h0, sec_pulse}, (k == 4) ? 16'h1 : 16'h0);
        end
        chk("mid_t0001", time_bcd, 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
